// File: rtl/ingress_pkt_buffer.sv
// ----------------------------------------------------------------------------
// ingress_pkt_buffer
//   Per-port store-and-forward ingress buffer. Incoming packets are written
//   speculatively behind a commit pointer. A packet becomes visible to the
//   reader only when its eop word arrives and the word count matches the
//   length field in its header. Malformed or oversized packets are discarded
//   by rolling the write pointer back to the commit pointer.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   wr_sop/wr_eop       first / last word flags of the incoming packet
//   wr_vld, wr_data     incoming word and its qualifier
//   next_data           pop request from the write arbiter
//   ready               at least one committed word is waiting
//   sop/eop/vld         registered flags of the popped word
//   out_data            registered popped word
//   overflow            one-cycle pulse: packet rejected for lack of space
//   err                 one-cycle pulse: packet or stray word dropped as malformed
//   almost_full         fewer than AF_TH free words (speculative occupancy)
//   drop_cnt            saturating count of dropped packets
//
// Header word: [3:0] dest, [6:4] priority, [13:7] length in words incl. header.
// ----------------------------------------------------------------------------
module ingress_pkt_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int AF_TH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_sop,
    input  logic              wr_eop,
    input  logic              wr_vld,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              next_data,
    output logic              ready,
    output logic              sop,
    output logic              eop,
    output logic              vld,
    output logic [DATA_W-1:0] out_data,
    output logic              overflow,
    output logic              err,
    output logic              almost_full,
    output logic [15:0]       drop_cnt
);
    localparam int PTR_W  = ADDR_W + 1;   // extra MSB separates full from empty
    localparam int FREE_W = ADDR_W + 2;
    localparam int LEN_W  = 7;

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} wstate_e;

    // Each entry is {sop, eop, data}.
    logic [DATA_W+1:0] mem [DEPTH];

    wstate_e           state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  cm_ptr_q, cm_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  pkt_cnt_q;          // committed packets not yet fully drained
    logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [16:0]       drop_sum;
    logic              err_q, err_d, ovf_q, ovf_d;
    logic              sop_q, eop_q, vld_q;
    logic [DATA_W-1:0] out_data_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              commit;
    logic [1:0]        drop_inc;
    logic              in_sop, in_word, pop, pop_eop;
    logic [LEN_W-1:0]  hdr_len, cnt_inc;
    logic [PTR_W-1:0]  sop_used, wr_used;
    logic [FREE_W-1:0] sop_free, wr_free;
    logic              hdr_reject, word_last;

    assign in_sop  = wr_vld & wr_sop;
    assign in_word = wr_vld & ~wr_sop;
    assign hdr_len = wr_data[13:7];
    assign cnt_inc = cnt_q + 7'd1;
    assign word_last = (cnt_inc == len_q);

    // A new header always starts at the commit pointer: in IDLE/DISCARD the
    // write pointer already equals it, and in RECV the partial packet is
    // rolled back in the same cycle. Space therefore excludes the partial.
    assign sop_used   = cm_ptr_q - rd_ptr_q;
    assign sop_free   = FREE_W'(DEPTH) - {1'b0, sop_used};
    assign hdr_reject = (hdr_len == '0) || (int'(hdr_len) > int'(sop_free));

    assign wr_used     = wr_ptr_q - rd_ptr_q;
    assign wr_free     = FREE_W'(DEPTH) - {1'b0, wr_used};
    assign almost_full = int'(wr_free) < AF_TH;

    assign ready   = (rd_ptr_q != cm_ptr_q);
    assign pop     = next_data & ready;
    assign pop_eop = pop & mem[rd_ptr_q[ADDR_W-1:0]][DATA_W];

    // ---------------- write FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- write FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (in_sop) begin
            if (hdr_reject || hdr_len == 7'd1) state_d = wr_eop ? IDLE : DISCARD;
            else                               state_d = wr_eop ? IDLE : RECV;
        end else if (in_word) begin
            case (state_q)
                RECV:    if (wr_eop) state_d = IDLE;
                         else if (word_last) state_d = DISCARD;
                DISCARD: if (wr_eop) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- write FSM: actions ----------------
    // NOTE: every signal gets a default first, so no path leaves a latch.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = wr_ptr_q[ADDR_W-1:0];
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        commit   = 1'b0;
        err_d    = 1'b0;
        ovf_d    = 1'b0;
        drop_inc = 2'd0;

        if (in_sop) begin
            if (state_q == RECV) begin          // missing eop: drop the partial
                err_d    = 1'b1;
                drop_inc = drop_inc + 2'd1;
                wr_ptr_d = cm_ptr_q;
            end
            if (hdr_len == '0) begin
                err_d    = 1'b1;
                drop_inc = drop_inc + 2'd1;
            end else if (hdr_reject) begin
                ovf_d    = 1'b1;
                drop_inc = drop_inc + 2'd1;
            end else begin
                ram_we   = 1'b1;
                ram_addr = cm_ptr_q[ADDR_W-1:0];
                len_d    = hdr_len;
                cnt_d    = 7'd1;
                if (hdr_len == 7'd1 && wr_eop) begin
                    commit   = 1'b1;
                    wr_ptr_d = cm_ptr_q + PTR_W'(1);
                    cm_ptr_d = cm_ptr_q + PTR_W'(1);
                end else if (hdr_len == 7'd1 || wr_eop) begin
                    // header alone already ends (or overruns) the packet wrongly
                    err_d    = 1'b1;
                    drop_inc = drop_inc + 2'd1;
                    wr_ptr_d = cm_ptr_q;
                end else begin
                    wr_ptr_d = cm_ptr_q + PTR_W'(1);
                end
            end
        end else if (in_word) begin
            case (state_q)
                IDLE: err_d = 1'b1;             // stray word outside a packet
                RECV: begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_inc;
                    if (wr_eop && word_last) begin
                        commit   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        cm_ptr_d = wr_ptr_q + PTR_W'(1);
                    end else if (wr_eop || word_last) begin
                        err_d    = 1'b1;
                        drop_inc = 2'd1;
                        wr_ptr_d = cm_ptr_q;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                end
                default: ;                      // DISCARD consumes silently
            endcase
        end
    end

    assign drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
    assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    // ---------------- storage ----------------
    // NOTE: the RAM is not reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= {wr_sop, wr_eop, wr_data};
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            vld_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            vld_q      <= pop;
            if (pop) begin
                {sop_q, eop_q, out_data_q} <= mem[rd_ptr_q[ADDR_W-1:0]];
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else begin
                sop_q <= 1'b0;
                eop_q <= 1'b0;
            end
            // simultaneous commit and eop-pop cancel out
            case ({commit, pop_eop})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + PTR_W'(1);
                2'b01:   pkt_cnt_q <= pkt_cnt_q - PTR_W'(1);
                default: pkt_cnt_q <= pkt_cnt_q;
            endcase
        end
    end

    assign sop      = sop_q;
    assign eop      = eop_q;
    assign vld      = vld_q;
    assign out_data = out_data_q;
    assign overflow = ovf_q;
    assign err      = err_q;
    assign drop_cnt = drop_cnt_q;

endmodule
